morse_key_capture: RTL and testbench

- Upstream stage of the Morse playback path.
- Converts a raw push-button (telegraph key) into the 10-bit packed Morse word consumed by the 10-bit morse holding register and the decomposer.
- Synchronises and debounces the key, times each press to classify it as dot or dash, and detects the end-of-letter gap.
- Emits the completed word with a one-cycle valid strobe.

---
 rtl/morse_key_capture.sv | 152 +++++++++++++++
 tb/tb_morse_key_capture.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/morse_key_capture.sv
// Telegraph key capture: sync, debounce, dot/dash timing, letter packing.
// Optional MORSE_KEY_CAPTURE_ABORT_EN: over-long press aborts the letter.
module morse_key_capture #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DASH_CYCLES     = 10000000,
  parameter int END_GAP_CYCLES  = 35000000,
  parameter int CNT_W           = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key,
  output logic [9:0] morse,
  output logic       valid,
  output logic       busy,
  output logic [2:0] sym_count,
  output logic       overflow
);

  typedef enum logic [2:0] {
    IDLE, PRESS, GAP, DONE, ABORT
  } state_e;

  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_TH =
    CNT_W'(DASH_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(END_GAP_CYCLES - 1);
`ifdef MORSE_KEY_CAPTURE_ABORT_EN
  localparam logic [CNT_W-1:0] ABORT_LIM =
    CNT_W'(4 * DASH_CYCLES);
`endif

  state_e           state_q, state_d;
  logic             s1_q, s2_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] gcnt_q, gcnt_d;
  logic [CNT_W-1:0] pcnt_inc;
  logic [9:0]       shadow_q, shadow_d;
  logic [9:0]       morse_q, morse_d;
  logic [2:0]       sym_q, sym_d;
  logic             ovf_q, ovf_d;
  logic             rise, fall;
  logic [1:0]       code;

  always_comb begin
    dcnt_d = '0;
    deb_d  = deb_q;
    if (s2_q != deb_q) begin
      if (dcnt_q == DB_LAST) deb_d = s2_q;
      else dcnt_d = dcnt_q + 1'b1;
    end
  end

  // Edges are taken from the debouncer update so the FSM moves with deb_q
  assign rise = deb_d & ~deb_q;
  assign fall = ~deb_d & deb_q;

  assign pcnt_inc = (&pcnt_q) ? pcnt_q : pcnt_q + 1'b1;
  assign code = (pcnt_inc >= DASH_TH) ? 2'b10 : 2'b01;

  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    gcnt_d   = gcnt_q;
    shadow_d = shadow_q;
    morse_d  = morse_q;
    sym_d    = sym_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d  = PRESS;
          pcnt_d   = '0;
          shadow_d = '0;
          sym_d    = '0;
          ovf_d    = 1'b0;
        end
      end
      PRESS: begin
        pcnt_d = pcnt_inc;
`ifdef MORSE_KEY_CAPTURE_ABORT_EN
        if (pcnt_inc >= ABORT_LIM) begin
          state_d  = ABORT;
          shadow_d = '0;
          sym_d    = '0;
        end else
`endif
        if (fall) begin
          if (sym_q < 3'd5) begin
            shadow_d[{sym_q, 1'b0} +: 2] = code;
            sym_d = sym_q + 3'd1;
          end else begin
            ovf_d = 1'b1;
          end
          state_d = GAP;
          gcnt_d  = '0;
        end
      end
      GAP: begin
        gcnt_d = gcnt_q + 1'b1;
        if (rise) begin
          state_d = PRESS;
          pcnt_d  = '0;
        end else if (gcnt_q == GAP_LAST) begin
          state_d = DONE;
          morse_d = shadow_q;
        end
      end
      DONE:  state_d = IDLE;
      ABORT: if (!deb_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      deb_q    <= 1'b0;
      dcnt_q   <= '0;
      pcnt_q   <= '0;
      gcnt_q   <= '0;
      shadow_q <= '0;
      morse_q  <= '0;
      sym_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= key;
      s2_q     <= s1_q;
      deb_q    <= deb_d;
      dcnt_q   <= dcnt_d;
      pcnt_q   <= pcnt_d;
      gcnt_q   <= gcnt_d;
      shadow_q <= shadow_d;
      morse_q  <= morse_d;
      sym_q    <= sym_d;
      ovf_q    <= ovf_d;
    end
  end

  assign morse     = morse_q;
  assign valid     = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sym_count = sym_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_morse_key_capture.sv
// Directed bench for morse_key_capture with small timing parameters.
// Define MORSE_KEY_CAPTURE_ABORT_EN for both RTL and bench to test abort.
module tb_morse_key_capture;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key = 1'b0;
  logic [9:0] morse;
  logic       valid;
  logic       busy;
  logic [2:0] sym_count;
  logic       overflow;

  morse_key_capture #(
    .DEBOUNCE_CYCLES(4),
    .DASH_CYCLES(20),
    .END_GAP_CYCLES(50),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key(key),
    .morse(morse),
    .valid(valid),
    .busy(busy),
    .sym_count(sym_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  int bcount = 0;
  logic [9:0] vmorse = '0;

  always @(negedge clk) begin
    if (valid) begin
      vcount = vcount + 1;
      vmorse = morse;
    end
    if (busy) bcount = bcount + 1;
  end

  typedef struct {
    int         np;
    int         p[6];
    int         gap;
    logic [9:0] m;
    int         sc;
    logic       ov;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic press(input int p);
    key = 1'b1;
    repeat (p) @(posedge clk);
    #1 key = 1'b0;
  endtask

  task automatic idle(input int g);
    repeat (g) @(posedge clk);
    #1;
  endtask

  initial begin
    int v0;
    int b0;
    bit found;

    tbl[0] = '{1, '{10, 0, 0, 0, 0, 0}, 15,
               10'b00_00_00_00_01, 1, 1'b0};
    tbl[1] = '{1, '{19, 0, 0, 0, 0, 0}, 15,
               10'b00_00_00_00_01, 1, 1'b0};
    tbl[2] = '{1, '{20, 0, 0, 0, 0, 0}, 15,
               10'b00_00_00_00_10, 1, 1'b0};
    tbl[3] = '{6, '{10, 10, 10, 10, 10, 10}, 15,
               10'b01_01_01_01_01, 5, 1'b1};
    tbl[4] = '{3, '{30, 10, 10, 0, 0, 0}, 15,
               10'b00_00_01_01_10, 3, 1'b0};
    tbl[5] = '{5, '{30, 30, 30, 30, 30, 0}, 15,
               10'b10_10_10_10_10, 5, 1'b0};

    for (int i = 0; i < 8; i++) begin
      key = ~key;
      @(posedge clk);
      #1;
    end
    chk("rst_morse", 32'(morse), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sym", 32'(sym_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    key = 1'b0;
    reset = 1'b1;
    idle(10);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_morse", 32'(morse), 0);
    chk("post_rst_valid_cnt", 32'(vcount), 0);

    for (int t = 0; t < 6; t++) begin
      v0 = vcount;
      for (int i = 0; i < tbl[t].np; i++) begin
        press(tbl[t].p[i]);
        if (i < tbl[t].np - 1) idle(tbl[t].gap);
      end
      idle(80);
      chk($sformatf("v%0d_nvalid", t), 32'(vcount - v0), 1);
      chk($sformatf("v%0d_vmorse", t), 32'(vmorse), 32'(tbl[t].m));
      chk($sformatf("v%0d_morse", t), 32'(morse), 32'(tbl[t].m));
      chk($sformatf("v%0d_sym", t), 32'(sym_count), 32'(tbl[t].sc));
      chk($sformatf("v%0d_ovf", t), 32'(overflow), 32'(tbl[t].ov));
      chk($sformatf("v%0d_busy", t), 32'(busy), 0);
    end

    v0 = vcount;
    press(30); idle(15);
    press(10); idle(15);
    press(30);
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("k_valid_seen", 32'(found), 1);
    chk("k_busy_at_valid", 32'(busy), 1);
    chk("k_morse", 32'(morse), 32'(10'b00_00_10_01_10));
    @(negedge clk);
    chk("k_valid_one_cycle", 32'(valid), 0);
    chk("k_busy_after", 32'(busy), 0);
    @(posedge clk);
    #1;
    idle(10);
    chk("k_nvalid", 32'(vcount - v0), 1);

    b0 = bcount;
    v0 = vcount;
    for (int r = 0; r < 3; r++)
      for (int w = 1; w <= 3; w++) begin
        press(w);
        idle(3);
      end
    idle(10);
    chk("bounce_busy", 32'(bcount - b0), 0);
    chk("bounce_nvalid", 32'(vcount - v0), 0);
    press(10);
    idle(80);
    chk("bounce_dot_nvalid", 32'(vcount - v0), 1);
    chk("bounce_dot_morse", 32'(morse), 32'(10'b01));

    v0 = vcount;
    press(10);
    idle(50);
    chk("gap_edge_no_valid", 32'(vcount - v0), 0);
    chk("gap_edge_busy", 32'(busy), 1);
    press(30);
    idle(80);
    chk("gap_edge_nvalid", 32'(vcount - v0), 1);
    chk("gap_edge_morse", 32'(morse), 32'(10'b10_01));
    chk("gap_edge_sym", 32'(sym_count), 2);

    v0 = vcount;
    press(30);
    idle(15);
    press(85);
    idle(80);
`ifdef MORSE_KEY_CAPTURE_ABORT_EN
    chk("abort_nvalid", 32'(vcount - v0), 0);
    chk("abort_morse", 32'(morse), 32'(10'b10_01));
    chk("abort_sym", 32'(sym_count), 0);
`else
    chk("long_nvalid", 32'(vcount - v0), 1);
    chk("long_morse", 32'(morse), 32'(10'b10_10));
    chk("long_sym", 32'(sym_count), 2);
`endif
    chk("long_busy", 32'(busy), 0);

    v0 = vcount;
    press(10);
    idle(10);
    reset = 1'b0;
    #1;
    chk("mid_rst_morse", 32'(morse), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_sym", 32'(sym_count), 0);
    idle(3);
    reset = 1'b1;
    idle(80);
    chk("mid_rst_nvalid", 32'(vcount - v0), 0);
    chk("mid_rst_morse_hold", 32'(morse), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got 0 want 1");
    $fatal(1, "timeout");
  end

endmodule
